// File: rtl/handshake_cdc_rx.sv
// Receive side of a toggle request/acknowledge bus crossing.
// The sender holds data_i stable and flips its request toggle. Once that
// toggle reaches this domain through the synchronizer, this block captures
// data_i into a small FIFO and mirrors the toggle back on ack_o. Captured
// words leave on a valid/ready stream.
//
// Stream handshake: a word moves downstream on every clk edge where
// valid_o && ready_i. valid_o never depends on ready_i. While valid_o is
// high and ready_i is low, valid_o and data_o hold stable. While valid_o is
// low, ready_i is ignored.
module handshake_cdc_rx #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_sync_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ack_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pend;
    logic             push;
    logic             pop;

    // A request is pending while the sender's toggle differs from our ack.
    // Full is judged on the registered count, so a pop that frees a slot
    // only allows the stalled request in on the following edge.
    always_comb begin
        pend = (req_sync_i != ack_o);
        push = pend && (count_o != FULL_COUNT);
        pop  = valid_o && ready_i;
    end

    assign valid_o = (count_o != '0);
    assign data_o  = mem[rd_ptr];

    // Storage write: capture the held sender bus into the slot at wr_ptr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Write pointer and ack toggle advance together, once per captured request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            ack_o  <= 1'b0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            ack_o  <= req_sync_i;
        end
    end

    // Read pointer advances on every accepted output word; DEPTH is a power
    // of two, so natural wrap gives the modulo.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: +1 on push, -1 on pop, unchanged when both or neither.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_o <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule
